// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads a multiplexed active-low 7-segment bus back into hex digits,
// capturing each digit once its pattern has been stable and publishing coherent 4-digit frames.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_seg,
    input  logic [3:0]  i_an,
    output logic [15:0] o_digits,
    output logic [3:0]  o_blank,
    output logic        o_frame_valid,
    output logic        o_digits_valid,
    output logic        o_bad_pattern
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t          r_state, w_next;
    logic [6:0]      r_seg_m, r_seg_s;
    logic [3:0]      r_an_m, r_an_s;
    logic [10:0]     r_prev;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [WW-1:0]   r_wd, w_wd_nxt;
    logic [15:0]     r_shadow, r_digits;
    logic [3:0]      r_shadow_blank, r_seen, r_blank;
    logic            r_fv, r_dv, r_bad;
    logic            w_chg, w_onehot, w_capture, w_valid, w_is_blank, w_good, w_frame;
    logic [3:0]      w_low, w_nib;
    logic [1:0]      w_idx;

    assign w_chg      = {r_seg_s, r_an_s} != r_prev;
    assign w_low      = ~r_an_s;
    assign w_onehot   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_idx      = w_low[3] ? 2'd3 : w_low[2] ? 2'd2 : w_low[1] ? 2'd1 : 2'd0;
    assign w_cnt_nxt  = w_chg ? CW'(1) : (r_cnt == CW'(STABLE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    assign w_is_blank = r_seg_s == 7'h7F;
    assign w_good     = w_capture && w_valid;
    assign w_frame    = r_seen == 4'hF;
    assign w_wd_nxt   = w_good ? '0 : (r_wd == WW'(TIMEOUT_CYCLES)) ? r_wd : r_wd + 1'b1;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE:   w_next = w_onehot ? SETTLE : IDLE;
            SETTLE: begin
                if (!w_onehot) w_next = IDLE;
                else if (w_cnt_nxt == CW'(STABLE_CYCLES)) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end
            end
            HOLD:   if (w_chg) w_next = w_onehot ? SETTLE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // 7F (all segments off) is a legal blank digit that reads as nibble 0
    always_comb begin
        w_valid = 1'b1;
        w_nib   = 4'h0;
        case (r_seg_s)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            7'h7F: w_nib = 4'h0;
            default: w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_m        <= '0;
            r_seg_s        <= '0;
            r_an_m         <= '0;
            r_an_s         <= '0;
            r_prev         <= '0;
            r_cnt          <= '0;
            r_state        <= IDLE;
            r_shadow       <= '0;
            r_shadow_blank <= '0;
            r_seen         <= '0;
            r_digits       <= '0;
            r_blank        <= '0;
            r_fv           <= 1'b0;
            r_dv           <= 1'b0;
            r_bad          <= 1'b0;
            r_wd           <= '0;
        end else begin
            r_seg_m <= i_seg;
            r_seg_s <= r_seg_m;
            r_an_m  <= i_an;
            r_an_s  <= r_an_m;
            r_prev  <= {r_seg_s, r_an_s};
            r_cnt   <= w_cnt_nxt;
            r_state <= w_next;
            r_bad   <= w_capture && !w_valid;
            r_fv    <= w_frame;
            r_wd    <= w_wd_nxt;
            if (w_good) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_nib;
                r_shadow_blank[w_idx]         <= w_is_blank;
            end
            r_seen <= (w_frame ? 4'd0 : r_seen) | (w_good ? 4'd1 << w_idx : 4'd0);
            if (w_frame) begin
                r_digits <= r_shadow;
                r_blank  <= r_shadow_blank;
            end
            r_dv <= w_frame ? 1'b1 : (w_wd_nxt == WW'(TIMEOUT_CYCLES)) ? 1'b0 : r_dv;
        end
    end

    assign o_digits       = r_digits;
    assign o_blank        = r_blank;
    assign o_frame_valid  = r_fv;
    assign o_digits_valid = r_dv;
    assign o_bad_pattern  = r_bad;
endmodule
